// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage: stalls the pipeline for LATENCY wait cycles, then pulses done.
// Optional MISALIGN_TRAP_EN: misaligned accesses skip the array and raise misaligned alongside done.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        misaligned
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [31:0]        wdata_reg;
    logic               op_write_reg;
    logic [31:0]        read_data_reg;
    logic               done_reg;
    logic               req;
    logic               access_edge;
    logic               access_ok;
    logic               mem_we;

    logic [31:0] mem [DEPTH_WORDS];

    assign req         = mem_read | mem_write;
    assign access_edge = (state_reg == S_WAIT) && (cnt_reg == '0);
    assign stall       = !rst && (((state_reg == S_IDLE) && req) || (state_reg == S_WAIT));
    assign done        = done_reg;
    assign read_data   = read_data_reg;

`ifdef MISALIGN_TRAP_EN
    logic mis_reg;
    logic misaligned_reg;
    logic unused_addr_bits;

    assign access_ok        = !mis_reg;
    assign misaligned       = misaligned_reg;
    assign unused_addr_bits = ^addr[31:IDX_W+2];

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_reg        <= 1'b0;
            misaligned_reg <= 1'b0;
        end else begin
            if (state_reg == S_IDLE && req)
                mis_reg <= (addr[1:0] != 2'b00);
            misaligned_reg <= access_edge && mis_reg;
        end
    end
`else
    logic unused_addr_bits;

    assign access_ok        = 1'b1;
    assign misaligned       = 1'b0;
    assign unused_addr_bits = ^{addr[31:IDX_W+2], addr[1:0]};
`endif

    // Write is gated by rst so a reset landing on the access edge leaves the array untouched.
    assign mem_we = !rst && access_edge && op_write_reg && access_ok;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[idx_reg] <= wdata_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            wdata_reg     <= '0;
            op_write_reg  <= 1'b0;
            read_data_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (req) begin
                        idx_reg      <= addr[IDX_W+1:2];
                        wdata_reg    <= write_data;
                        op_write_reg <= mem_write;
                        cnt_reg      <= CNT_W'(LATENCY - 1);
                        state_reg    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_reg == '0) begin
                        if (!op_write_reg && access_ok)
                            read_data_reg <= mem[idx_reg];
                        done_reg  <= 1'b1;
                        state_reg <= S_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_RESP: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: table-driven accesses with a scoreboard queue,
// plus hand-written reset-in-WAIT and misaligned-access sequences.
module tb_data_mem_responder;
    localparam int LATENCY     = 2;
    localparam int DEPTH_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        done;
    logic        misaligned;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int last_accept = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] a;
        logic [31:0] d;
        logic        b2b;
        logic [31:0] exp_rd;
    } vec_t;

    data_mem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data),
        .stall      (stall),
        .done       (done),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One access: drive in the accept cycle, scramble inputs during WAIT, wait (bounded) for done.
    task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_mis, input string name);
        int   lat;
        bit   got;
        exp_t e;
        @(posedge clk); #1;
        mem_write = w; mem_read = r; addr = a; write_data = d;
        last_accept = cyc;
        sb_q.push_back('{exp_rd, exp_mis, name});
        @(negedge clk);
        chk({name, ".stall_accept"}, 32'(stall), 32'd1);
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                addr = ~a;
                write_data = ~d;
            end
            @(negedge clk);
            if (done) got = 1;
            else if (lat <= LATENCY) chk({name, ".stall_wait"}, 32'(stall), 32'd1);
        end
        chk({name, ".latency"}, 32'(lat), 32'(LATENCY + 1));
        e = sb_q.pop_front();
        if (got) begin
            chk({name, ".stall_done"}, 32'(stall), 32'd0);
            chk({name, ".read_data"}, read_data, e.rdata);
            chk({name, ".misaligned"}, 32'(misaligned), 32'(e.mis));
            $display("txn %s: addr=%h wr=%b rd=%b read_data=%h mis=%b lat=%0d",
                     name, a, w, r, read_data, misaligned, lat);
        end else begin
            err_cnt++;
            $display("FAIL %s.timeout: got no done expected done within %0d cycles", name, LATENCY + 1);
        end
    endtask

    task automatic idle(input string name);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk({name, ".done_pulse"}, 32'(done), 32'd0);
        chk({name, ".stall_idle"}, 32'(stall), 32'd0);
    endtask

    vec_t vecs[11];
    logic [31:0] rd_now;
    int prev_accept;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0024, 32'h0000_CAFE, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0024, 32'h0,         1'b1, 32'h0000_CAFE};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h1111_2222, 1'b0, 32'h0000_CAFE};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         1'b1, 32'h1111_2222};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0030, 32'hA5A5_A5A5, 1'b0, 32'h1111_2222};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0030, 32'h0,         1'b1, 32'hA5A5_A5A5};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0BAD_F00D, 1'b0, 32'hA5A5_A5A5};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0BAD_F00D};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};

        // Reset with a pending read: stall must be held low while rst is high.
        rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = '0; write_data = '0;
        @(negedge clk);
        chk("reset.stall_forced", 32'(stall), 32'd0);
        @(negedge clk);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.misaligned", 32'(misaligned), 32'd0);
        chk("reset.read_data", read_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        chk("reset.idle_stall", 32'(stall), 32'd0);

        for (int i = 0; i < 11; i++) begin
            if (!vecs[i].b2b) idle($sformatf("vec%0d.pre", i));
            prev_accept = last_accept;
            access(vecs[i].wr, vecs[i].rd, vecs[i].a, vecs[i].d, vecs[i].exp_rd, 1'b0,
                   $sformatf("vec%0d", i));
            if (vecs[i].b2b) chk($sformatf("vec%0d.period", i), 32'(last_accept - prev_accept),
                                 32'(LATENCY + 2));
        end
        idle("hold.a");
        idle("hold.b");
        chk("hold.read_data", read_data, 32'hDEAD_BEEF);

        // Misaligned store then load of the same word.
        idle("mis.pre");
        access(1'b0, 1'b1, 32'h0000_0024, 32'h0, 32'h0000_CAFE, 1'b0, "mis.load_cafe");
`ifdef MISALIGN_TRAP_EN
        access(1'b1, 1'b0, 32'h0000_0013, 32'hFFFF_FFFF, 32'h0000_CAFE, 1'b1, "mis.store");
        access(1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, "mis.load_old");
        rd_now = 32'hDEAD_BEEF;
`else
        access(1'b1, 1'b0, 32'h0000_0013, 32'hFFFF_FFFF, 32'h0000_CAFE, 1'b0, "mis.store");
        access(1'b0, 1'b1, 32'h0000_0010, 32'h0, 32'hFFFF_FFFF, 1'b0, "mis.load_new");
        rd_now = 32'hFFFF_FFFF;
`endif

        // Reset landing on the final WAIT edge must suppress the store.
        idle("rstw.pre");
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0000_0005, rd_now, 1'b0, "rstw.preload");
        idle("rstw.gap");
        @(posedge clk); #1;
        mem_write = 1'b1; mem_read = 1'b0; addr = 32'h20; write_data = 32'h1234;
        for (int k = 0; k < LATENCY; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; mem_write = 1'b0;
        @(negedge clk);
        chk("rstw.stall_in_rst", 32'(stall), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rstw.done%0d", k), 32'(done), 32'd0);
            chk($sformatf("rstw.stall%0d", k), 32'(stall), 32'd0);
        end
        chk("rstw.read_data", read_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle("rstw.post");
        access(1'b0, 1'b1, 32'h0000_0020, 32'h0, 32'h0000_0005, 1'b0, "rstw.load");
        idle("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
